// File: rtl/smmha_engine_if.sv
// smmha engine stream interface
// a: source stream into the engine, d: result stream out of it
interface smmha_engine_if #(
  parameter int DATA_W = 32
) ();

  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              d_valid;
  logic [DATA_W-1:0] d_data;
  logic              d_ready;

  modport master (
    output a_valid,
    output a_data,
    input  a_ready,
    input  d_valid,
    input  d_data,
    output d_ready
  );

  modport slave (
    input  a_valid,
    input  a_data,
    output a_ready,
    output d_valid,
    output d_data,
    input  d_ready
  );

endinterface

// File: rtl/smmha_engine.sv
// smmha streaming engine
// element-wise op against a latched scalar, 2-stage pipe
module smmha_engine #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] operand_i,
  input  logic [1:0]        operation_i,
  smmha_engine_if.slave     bus,
  output logic [LEN_W-1:0]  cnt_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [0:0] {
    S_IDLE,
    S_RUN
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_SRA
  } op_e;

  state_e            state_q;
  state_e            state_d;
  logic              done_q;
  logic              done_d;

  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] opnd_q;
  op_e               op_q;

  logic [LEN_W-1:0]  in_cnt_q;
  logic [LEN_W-1:0]  cnt_q;

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_data_q;

  logic              run;
  logic              adv2;
  logic              a_ready;
  logic              in_fire;
  logic              out_fire;
  logic              last_out;
  logic              start_ok;
  logic [DATA_W-1:0] result;

  assign run      = (state_q == S_RUN);
  assign adv2     = s1_valid_q & (~s2_valid_q | bus.d_ready);
  assign a_ready  = run & (in_cnt_q < len_q)
                  & (~s1_valid_q | adv2);
  assign in_fire  = bus.a_valid & a_ready;
  assign out_fire = s2_valid_q & bus.d_ready;
  assign last_out = ((cnt_q + LEN_W'(1)) == len_q);
  assign start_ok = (state_q == S_IDLE) & start_i;

  assign bus.a_ready = a_ready;
  assign bus.d_valid = s2_valid_q;
  assign bus.d_data  = s2_data_q;
  assign cnt_o       = cnt_q;
  assign busy_o      = run;
  assign done_o      = done_q;

  // element operation against the latched scalar
  always_comb begin
    result = '0;
    unique case (op_q)
      OP_ADD: result = bus.a_data + opnd_q;
      OP_SUB: result = bus.a_data - opnd_q;
      OP_MUL: result = bus.a_data * opnd_q;
      OP_SRA: result = $signed(bus.a_data)
                       >>> opnd_q[SH_W-1:0];
      default: result = '0;
    endcase
  end

  // job sequencing: clear wins, zero-length jobs finish at once
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (out_fire && last_out) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state and done-pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // job configuration and progress counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q    <= '0;
      opnd_q   <= '0;
      op_q     <= OP_ADD;
      in_cnt_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      in_cnt_q <= '0;
      cnt_q    <= '0;
    end else if (start_ok) begin
      len_q    <= len_i;
      opnd_q   <= operand_i;
      op_q     <= op_e'(operation_i);
      in_cnt_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (in_fire) begin
        in_cnt_q <= in_cnt_q + LEN_W'(1);
      end
      if (out_fire) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
    end
  end

  // stage 2: output register, holds while the sink stalls
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else if (clear_i) begin
      s2_valid_q <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= 1'b1;
      s2_data_q  <= s1_data_q;
    end else if (out_fire) begin
      s2_valid_q <= 1'b0;
    end
  end

  // stage 1: captures the computed element
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else if (clear_i) begin
      s1_valid_q <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_data_q  <= result;
    end else if (adv2) begin
      s1_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_smmha_engine.sv
// smmha engine directed testbench
// linear directed steps with immediate assertions
module tb_smmha_engine;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic [31:0] opnd = '0;
  logic [1:0]  opc = '0;
  logic [15:0] cnt;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  smmha_engine_if #(.DATA_W(32)) bus ();

  smmha_engine #(
    .DATA_W(32),
    .LEN_W(16)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .clear_i    (clear),
    .start_i    (start),
    .len_i      (len),
    .operand_i  (opnd),
    .operation_i(opc),
    .bus        (bus),
    .cnt_o      (cnt),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] calc(logic [1:0] op,
                                       logic [31:0] a,
                                       logic [31:0] b);
    logic [31:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a * b;
      default: r = $signed(a) >>> b[4:0];
    endcase
    return r;
  endfunction

  task automatic begin_job(logic [15:0] l, logic [1:0] o,
                           logic [31:0] od);
    start = 1'b1;
    len   = l;
    opc   = o;
    opnd  = od;
    tick();
    start = 1'b0;
  endtask

  task automatic run1(string tag, logic [1:0] o,
                      logic [31:0] od, logic [31:0] a,
                      logic [31:0] exp);
    begin_job(16'd1, o, od);
    bus.a_valid = 1'b1;
    bus.a_data  = a;
    tick();
    bus.a_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, bus.d_valid, 1);
    chk({tag, "_data"}, bus.d_data, exp);
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_cnt"}, cnt, 1);
  endtask

  task automatic run_job(string tag, logic [15:0] l,
                         logic [1:0] o, logic [31:0] od,
                         logic [31:0] base, logic [31:0] stride);
    int in_idx;
    int out_idx;
    in_idx  = 0;
    out_idx = 0;
    bus.d_ready = 1'b1;
    begin_job(l, o, od);
    for (int c = 0; c < 100 && out_idx < int'(l); c++) begin
      bus.a_valid = (in_idx < int'(l));
      bus.a_data  = base + stride * in_idx;
      #1;
      if (bus.d_valid) begin
        chk({tag, "_data"}, bus.d_data,
            calc(o, base + stride * out_idx, od));
        out_idx++;
      end
      if (bus.a_valid && bus.a_ready) in_idx++;
      tick();
    end
    bus.a_valid = 1'b0;
    chk({tag, "_outs"}, out_idx, l);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_cnt"}, cnt, l);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin : main
    int in_idx;
    int out_idx;
    int stalls;
    int budget;
    logic prev_stall;
    logic [31:0] prev_data;

    bus.a_valid = 1'b0;
    bus.a_data  = '0;
    bus.d_ready = 1'b1;

    // reset state
    #12;
    chk("rst_a_ready", bus.a_ready, 0);
    chk("rst_d_valid", bus.d_valid, 0);
    chk("rst_d_data", bus.d_data, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();

    // basic ADD, len 4, operand 5
    begin_job(16'd4, 2'd0, 32'd5);
    chk("add_busy", busy, 1);
    chk("add_a_ready", bus.a_ready, 1);
    bus.a_valid = 1'b1;
    bus.a_data  = 32'd1;
    tick();
    chk("add_lat1", bus.d_valid, 0);
    bus.a_data = 32'd2;
    tick();
    chk("add_lat2", bus.d_valid, 1);
    chk("add_o0", bus.d_data, 32'd6);
    bus.a_data = 32'd3;
    tick();
    chk("add_o1", bus.d_data, 32'd7);
    chk("add_cnt1", cnt, 1);
    bus.a_data = 32'd4;
    tick();
    chk("add_o2", bus.d_data, 32'd8);
    chk("add_full_in", bus.a_ready, 0);
    chk("add_cnt2", cnt, 2);
    bus.a_valid = 1'b0;
    tick();
    chk("add_o3", bus.d_data, 32'd9);
    chk("add_cnt3", cnt, 3);
    chk("add_nodone", done, 0);
    tick();
    chk("add_done", done, 1);
    chk("add_cnt4", cnt, 4);
    chk("add_idle", busy, 0);
    chk("add_drain", bus.d_valid, 0);
    tick();
    chk("add_done_pulse", done, 0);
    chk("add_cnt_hold", cnt, 4);

    // opcode coverage
    run1("sub", 2'd1, 32'd7, 32'd3, 32'hFFFF_FFFC);
    run1("mul", 2'd2, 32'h1_0000, 32'h1_0000, 32'h0);
    run1("mul2", 2'd2, 32'd3, 32'h1_2345, 32'h3_69CF);
    run1("sra", 2'd3, 32'd4, 32'h8000_0000, 32'hF800_0000);
    run1("sra_pos", 2'd3, 32'd36, 32'h4000_0000,
         32'h0400_0000);

    // backpressure, len 8, a_valid always high
    begin_job(16'd8, 2'd0, 32'h100);
    bus.a_valid = 1'b1;
    in_idx     = 0;
    out_idx    = 0;
    stalls     = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 300 && out_idx < 8; c++) begin
      bus.d_ready = (c < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.a_data  = 32'd10 + in_idx;
      #1;
      if (prev_stall) begin
        chk("bp_hold_valid", bus.d_valid, 1);
        chk("bp_hold_data", bus.d_data, prev_data);
      end
      if (in_idx - out_idx == 2 && !bus.d_ready) begin
        chk("bp_full_stall", bus.a_ready, 0);
        stalls++;
      end
      if (in_idx == 8) chk("bp_no_extra", bus.a_ready, 0);
      prev_stall = bus.d_valid && !bus.d_ready;
      prev_data  = bus.d_data;
      if (bus.d_valid && bus.d_ready) begin
        chk("bp_data", bus.d_data, 32'h10A + out_idx);
        out_idx++;
      end
      if (bus.a_ready) in_idx++;
      tick();
    end
    bus.a_valid = 1'b0;
    bus.d_ready = 1'b1;
    chk("bp_outs", out_idx, 8);
    chk("bp_ins", in_idx, 8);
    chk("bp_stall_seen", (stalls != 0), 1);
    chk("bp_done", done, 1);
    chk("bp_cnt", cnt, 8);
    chk("bp_busy", busy, 0);

    // zero-length job
    bus.a_valid = 1'b1;
    bus.a_data  = 32'd99;
    begin_job(16'd0, 2'd0, 32'd1);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_a_ready", bus.a_ready, 0);
    tick();
    chk("len0_pulse", done, 0);
    chk("len0_a_ready2", bus.a_ready, 0);
    bus.a_valid = 1'b0;

    // start during RUN must not relatch
    begin_job(16'd2, 2'd0, 32'd1);
    start = 1'b1;
    len   = 16'd5;
    opc   = 2'd2;
    opnd  = 32'd3;
    bus.a_valid = 1'b1;
    bus.a_data  = 32'd10;
    tick();
    start = 1'b0;
    bus.a_data = 32'd20;
    tick();
    chk("rerun_len", bus.a_ready, 0);
    chk("rerun_o0", bus.d_data, 32'd11);
    tick();
    chk("rerun_o1", bus.d_data, 32'd21);
    tick();
    chk("rerun_done", done, 1);
    chk("rerun_cnt", cnt, 2);
    bus.a_valid = 1'b0;

    // clear mid-job after three outputs
    begin_job(16'd10, 2'd0, 32'd0);
    in_idx = 0;
    budget = 0;
    while (cnt != 16'd3 && budget < 50) begin
      bus.a_valid = 1'b1;
      bus.a_data  = in_idx;
      #1;
      if (bus.a_ready) in_idx++;
      tick();
      budget++;
    end
    chk("clr_pre_cnt", cnt, 3);
    chk("clr_pre_busy", busy, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_d_valid", bus.d_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_cnt", cnt, 0);
    chk("clr_done", done, 0);
    chk("clr_a_ready", bus.a_ready, 0);
    tick();
    chk("clr_no_done", done, 0);
    chk("clr_d_valid2", bus.d_valid, 0);
    bus.a_valid = 1'b0;
    run_job("clr_job", 16'd2, 2'd1, 32'd1, 32'd100, 32'd100);

    // async reset mid-job
    begin_job(16'd5, 2'd0, 32'd7);
    bus.a_valid = 1'b1;
    bus.a_data  = 32'd1;
    tick();
    bus.a_data = 32'd2;
    tick();
    bus.a_data = 32'd3;
    tick();
    chk("arst_pre_valid", bus.d_valid, 1);
    chk("arst_pre_cnt", cnt, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_a_ready", bus.a_ready, 0);
    chk("arst_d_valid", bus.d_valid, 0);
    chk("arst_d_data", bus.d_data, 0);
    chk("arst_cnt", cnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    chk("arst_rel_busy", busy, 0);
    chk("arst_rel_a_ready", bus.a_ready, 0);
    chk("arst_rel_d_valid", bus.d_valid, 0);
    bus.a_valid = 1'b0;
    run_job("arst_job", 16'd1, 2'd0, 32'd5, 32'd41, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
